uv_rotation_scheduler: RTL and testbench
========================================

// Module: uv_rotation_scheduler
// PURPOSE
// - Sequencer/arbiter for the shared 4-lane U/V CORDIC rotation datapath (process2x4_UV).
// - Two requesters share the datapath: U-side (row rotations) and V-side (column rotations).
// - Round-robin grant; drives ce/sel/shift/count/sign_in/sign_rotation/index per micro-rotation.
// - Replays the captured direction-bit vector, then reports completion to the granted requester.
// PARAMETERS
// - WIDTH_SHIFT_BIT  4   shift/count width; N_ITER <= 2**WIDTH_SHIFT_BIT
// - N_ITER          16   CORDIC micro-rotations per job
// - WIDTH_INDEX      2   index width (lane select forwarded to datapath)
// - PIPE_LAT         1   datapath output register latency (cycles, >=1)
// PORTS
// - clk            in   1                clock, rising edge
// - rst            in   1                synchronous reset, active-high
// - req_u          in   1                U-side job request; hold until gnt_u
// - dir_u          in   N_ITER           U-side direction bits, bit k = iteration k, 1 = negative
// - idx_u          in   WIDTH_INDEX      U-side lane index
// - rot_u          in   1                U-side sign_rotation value
// - req_v/dir_v/idx_v/rot_v  in  (same)  V-side equivalents
// - gnt_u, gnt_v   out  1                1-cycle accept pulse; inputs captured that cycle
// - done_u, done_v out  1                1-cycle completion pulse; datapath outputs valid
// - busy           out  1                high from cycle after grant through DONE
// - ce, sel        out  1                datapath enable; sel=1 loads external x/y, 0 = feedback
// - shift          out  WIDTH_SHIFT_BIT  micro-rotation index k
// - count          out  WIDTH_SHIFT_BIT  iterations remaining after current (N_ITER-1-k)
// - sign_in        out  1                direction bit for iteration k
// - sign_rotation  out  1                captured rot_* of granted job, held for job
// - index          out  WIDTH_INDEX      captured idx_* of granted job, held for job
// BEHAVIOUR
// - All outputs registered. Reset (rst=1 at clk edge): state=IDLE; every output 0; last_grant=V.
// - Reset mid-job: abort immediately; no done pulse; captured job state discarded.
// - States: IDLE -> LOAD -> ITER -> FLUSH -> DONE -> IDLE.
// - IDLE: if any req, assert gnt to winner, capture dir/idx/rot, -> LOAD. Else stay, ce=0.
// - Arbitration: only one requester -> it wins. Both -> the one not equal to last_grant;
//   last_grant updated on each grant. First tie after reset goes to U.
// - LOAD (1 cycle): ce=1, sel=1, shift=0, count=N_ITER-1, sign_in=0.
// - ITER (N_ITER cycles, k=0..N_ITER-1): ce=1, sel=0, shift=k, count=N_ITER-1-k,
//   sign_in=dir[k]. Exit to FLUSH after k=N_ITER-1.
// - FLUSH (PIPE_LAT cycles): ce=0, sel=0, shift/count/sign_in hold last ITER values.
// - DONE (1 cycle): done_<granted>=1, ce=0; -> IDLE. No grant in DONE.
// - busy=1 in LOAD, ITER, FLUSH, DONE; 0 in IDLE.
// - Grant-to-grant period = PIPE_LAT + N_ITER + 3 cycles (20 at defaults).
// - index/sign_rotation change only on grant; hold values after DONE until next grant.
// - Requests raised while busy are queued by the requester (req held); not lost, not granted early.
// - req deasserted before grant: treated as withdrawn, no side effects.
// - Counter k is WIDTH_SHIFT_BIT wide; it never wraps, terminal compare is k==N_ITER-1.
// TESTING
// - Reset: hold rst 3 cycles with req_u=1 -> all outputs 0, no gnt; first gnt_u the cycle after rst drops.
// - Single U job, dir_u=16'hA5A5, idx_u=2, rot_u=1 -> gnt_u at t0; LOAD t1 (sel=1);
//   t2..t17 shift=0..15, count=15..0, sign_in=1,0,1,0,0,1,0,1,...; done_u at t19; index=2, sign_rotation=1 throughout.
// - req_u and req_v both high from reset -> grants alternate U,V,U,V at 20-cycle spacing.
// - V job active, req_u raised mid-ITER -> no gnt_u until IDLE; gnt_u on cycle after done_v.
// - rst asserted during ITER at k=7 -> next cycle all outputs 0, no done_*, busy=0; new request served normally.
// - PIPE_LAT=3 build -> 3 FLUSH cycles with ce=0; done at t21; period 22.

Source files
------------

// File: rtl/uv_rotation_scheduler.sv
// uv_rotation_scheduler: round-robin sequencer for the shared 4-lane U/V CORDIC
// rotation datapath. It grants one requester at a time, replays that job's
// captured direction bits one micro-rotation per cycle, waits out the datapath
// output pipeline, then pulses done to the requester that was granted.
// Every output is a flop. The state register leads the output flops by one
// cycle, so the outputs seen in a cycle describe the state that was active
// during the previous cycle.
module uv_rotation_scheduler #(
  parameter int WIDTH_SHIFT_BIT = 4,
  parameter int N_ITER          = 16,
  parameter int WIDTH_INDEX     = 2,
  parameter int PIPE_LAT        = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_u,
  input  logic [N_ITER-1:0]          dir_u,
  input  logic [WIDTH_INDEX-1:0]     idx_u,
  input  logic                       rot_u,
  input  logic                       req_v,
  input  logic [N_ITER-1:0]          dir_v,
  input  logic [WIDTH_INDEX-1:0]     idx_v,
  input  logic                       rot_v,
  output logic                       gnt_u,
  output logic                       gnt_v,
  output logic                       done_u,
  output logic                       done_v,
  output logic                       busy,
  output logic                       ce,
  output logic                       sel,
  output logic [WIDTH_SHIFT_BIT-1:0] shift,
  output logic [WIDTH_SHIFT_BIT-1:0] count,
  output logic                       sign_in,
  output logic                       sign_rotation,
  output logic [WIDTH_INDEX-1:0]     index
);

  localparam int FW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [WIDTH_SHIFT_BIT-1:0] K_LAST = WIDTH_SHIFT_BIT'(N_ITER - 1);
  localparam logic [FW-1:0]              F_LAST = FW'(PIPE_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_FLUSH,
    S_DONE
  } state_e;

  state_e                     state_q, state_d;
  logic [WIDTH_SHIFT_BIT-1:0] k_q, k_d;
  logic [FW-1:0]              f_q, f_d;
  logic [N_ITER-1:0]          dir_q, dir_d;
  logic                       owner_v_q, owner_v_d;   // 1 = V-side job in flight
  logic                       last_v_q, last_v_d;     // 1 = most recent grant went to V
  logic                       win_v;

  logic                       gnt_u_q, gnt_u_d;
  logic                       gnt_v_q, gnt_v_d;
  logic                       done_u_q, done_u_d;
  logic                       done_v_q, done_v_d;
  logic                       busy_q, busy_d;
  logic                       ce_q, ce_d;
  logic                       sel_q, sel_d;
  logic [WIDTH_SHIFT_BIT-1:0] shift_q, shift_d;
  logic [WIDTH_SHIFT_BIT-1:0] count_q, count_d;
  logic                       sign_in_q, sign_in_d;
  logic                       sign_rot_q, sign_rot_d;
  logic [WIDTH_INDEX-1:0]     index_q, index_d;

  // State, job context and output registers; reset aborts any job in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      f_q        <= '0;
      dir_q      <= '0;
      owner_v_q  <= 1'b0;
      last_v_q   <= 1'b1;
      gnt_u_q    <= 1'b0;
      gnt_v_q    <= 1'b0;
      done_u_q   <= 1'b0;
      done_v_q   <= 1'b0;
      busy_q     <= 1'b0;
      ce_q       <= 1'b0;
      sel_q      <= 1'b0;
      shift_q    <= '0;
      count_q    <= '0;
      sign_in_q  <= 1'b0;
      sign_rot_q <= 1'b0;
      index_q    <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      f_q        <= f_d;
      dir_q      <= dir_d;
      owner_v_q  <= owner_v_d;
      last_v_q   <= last_v_d;
      gnt_u_q    <= gnt_u_d;
      gnt_v_q    <= gnt_v_d;
      done_u_q   <= done_u_d;
      done_v_q   <= done_v_d;
      busy_q     <= busy_d;
      ce_q       <= ce_d;
      sel_q      <= sel_d;
      shift_q    <= shift_d;
      count_q    <= count_d;
      sign_in_q  <= sign_in_d;
      sign_rot_q <= sign_rot_d;
      index_q    <= index_d;
    end
  end

  // Next-state sequencing: IDLE -> LOAD -> ITER x N_ITER -> FLUSH x PIPE_LAT -> DONE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (req_u || req_v) state_d = S_LOAD;
      S_LOAD:  state_d = S_ITER;
      S_ITER:  if (k_q == K_LAST) state_d = S_FLUSH;
      S_FLUSH: if (f_q == F_LAST) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Round-robin pick: a lone requester wins, a tie goes to the side not granted last.
  always_comb begin
    win_v = req_v && (!req_u || !last_v_q);
  end

  // Output and job-context values to register for the current state.
  always_comb begin
    k_d        = k_q;
    f_d        = f_q;
    dir_d      = dir_q;
    owner_v_d  = owner_v_q;
    last_v_d   = last_v_q;
    gnt_u_d    = 1'b0;
    gnt_v_d    = 1'b0;
    done_u_d   = 1'b0;
    done_v_d   = 1'b0;
    busy_d     = 1'b1;
    ce_d       = 1'b0;
    sel_d      = 1'b0;
    shift_d    = shift_q;
    count_d    = count_q;
    sign_in_d  = sign_in_q;
    sign_rot_d = sign_rot_q;
    index_d    = index_q;
    unique case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (req_u || req_v) begin
          gnt_u_d    = !win_v;
          gnt_v_d    = win_v;
          owner_v_d  = win_v;
          last_v_d   = win_v;
          dir_d      = win_v ? dir_v : dir_u;
          index_d    = win_v ? idx_v : idx_u;
          sign_rot_d = win_v ? rot_v : rot_u;
        end
      end
      S_LOAD: begin
        ce_d      = 1'b1;
        sel_d     = 1'b1;
        shift_d   = '0;
        count_d   = K_LAST;
        sign_in_d = 1'b0;
        k_d       = '0;
      end
      S_ITER: begin
        ce_d      = 1'b1;
        shift_d   = k_q;
        count_d   = K_LAST - k_q;
        sign_in_d = dir_q[k_q];
        f_d       = '0;
        // k saturates at the terminal value instead of wrapping
        if (k_q != K_LAST) k_d = k_q + 1'b1;
      end
      S_FLUSH: begin
        if (f_q != F_LAST) f_d = f_q + 1'b1;
      end
      S_DONE: begin
        done_u_d = !owner_v_q;
        done_v_d = owner_v_q;
      end
      default: busy_d = 1'b0;
    endcase
  end

  assign gnt_u         = gnt_u_q;
  assign gnt_v         = gnt_v_q;
  assign done_u        = done_u_q;
  assign done_v        = done_v_q;
  assign busy          = busy_q;
  assign ce            = ce_q;
  assign sel           = sel_q;
  assign shift         = shift_q;
  assign count         = count_q;
  assign sign_in       = sign_in_q;
  assign sign_rotation = sign_rot_q;
  assign index         = index_q;

endmodule

// File: tb/tb_uv_rotation_scheduler.sv
// Testbench for uv_rotation_scheduler: a job-timeline reference model predicts
// every output per cycle from grant time and phase arithmetic; directed
// scenarios add fixed-cycle expectations, and a PIPE_LAT=3 instance is checked
// for its longer flush.
module tb_uv_rotation_scheduler;

  localparam int N = 16;
  localparam int P = 1;
  localparam int T = N + P + 3;   // grant-to-grant period

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_u = 1'b0, req_v = 1'b0;
  logic [15:0] dir_u = '0, dir_v = '0;
  logic [1:0]  idx_u = '0, idx_v = '0;
  logic        rot_u = 1'b0, rot_v = 1'b0;

  logic        gnt_u, gnt_v, done_u, done_v, busy, ce, sel, sign_in, sign_rotation;
  logic [3:0]  shift, count;
  logic [1:0]  index;

  logic        gnt3_u, gnt3_v, done3_u, done3_v, busy3, ce3, sel3, sign3, rot3;
  logic [3:0]  shift3, count3;
  logic [1:0]  index3;

  uv_rotation_scheduler #(.WIDTH_SHIFT_BIT(4), .N_ITER(N), .WIDTH_INDEX(2), .PIPE_LAT(P)) dut (
    .clk(clk), .rst(rst),
    .req_u(req_u), .dir_u(dir_u), .idx_u(idx_u), .rot_u(rot_u),
    .req_v(req_v), .dir_v(dir_v), .idx_v(idx_v), .rot_v(rot_v),
    .gnt_u(gnt_u), .gnt_v(gnt_v), .done_u(done_u), .done_v(done_v), .busy(busy),
    .ce(ce), .sel(sel), .shift(shift), .count(count), .sign_in(sign_in),
    .sign_rotation(sign_rotation), .index(index)
  );

  uv_rotation_scheduler #(.WIDTH_SHIFT_BIT(4), .N_ITER(N), .WIDTH_INDEX(2), .PIPE_LAT(3)) dut3 (
    .clk(clk), .rst(rst),
    .req_u(req_u), .dir_u(dir_u), .idx_u(idx_u), .rot_u(rot_u),
    .req_v(req_v), .dir_v(dir_v), .idx_v(idx_v), .rot_v(rot_v),
    .gnt_u(gnt3_u), .gnt_v(gnt3_v), .done_u(done3_u), .done_v(done3_v), .busy(busy3),
    .ce(ce3), .sel(sel3), .shift(shift3), .count(count3), .sign_in(sign3),
    .sign_rotation(rot3), .index(index3)
  );

  always #5 clk = ~clk;

  logic [18:0] dut_vec;
  assign dut_vec = {gnt_u, gnt_v, done_u, done_v, busy, ce, sel,
                    shift, count, sign_in, sign_rotation, index};

  int checks = 0;
  int errors = 0;

  // Reference model: one job timeline described by its grant cycle.
  int          cyc = 0;
  bit          m_act = 0;
  int          m_g = 0;
  bit          m_own = 0;     // 1 = V
  bit          m_last = 1;    // 1 = V
  logic [15:0] m_dir = '0;
  logic [1:0]  m_idx = '0;
  bit          m_rot = 0;
  logic [3:0]  m_shift = '0, m_count = '0;
  bit          m_sign = 0;

  task automatic model_update();
    int p;
    bit w;
    if (rst) begin
      m_act = 0; m_last = 1; m_idx = '0; m_rot = 0;
      m_shift = '0; m_count = '0; m_sign = 0;
    end else begin
      if ((!m_act || (cyc - m_g) >= T) && (req_u || req_v)) begin
        w = (req_u && req_v) ? !m_last : req_v;
        m_own = w; m_last = w; m_g = cyc; m_act = 1;
        m_dir = w ? dir_v : dir_u;
        m_idx = w ? idx_v : idx_u;
        m_rot = w ? rot_v : rot_u;
      end
      if (m_act) begin
        p = cyc - m_g;
        if (p == 1) begin
          m_shift = 4'd0; m_count = 4'(N - 1); m_sign = 0;
        end else if (p >= 2 && p <= N + 1) begin
          m_shift = 4'(p - 2); m_count = 4'(N - 1 - (p - 2)); m_sign = m_dir[p - 2];
        end
      end
    end
  endtask

  function automatic logic [18:0] model_vec();
    int p;
    bit gu, gv, du, dv, b, c, s;
    p = m_act ? (cyc - m_g) : T;
    gu = (p == 0) && !m_own;
    gv = (p == 0) && m_own;
    du = (p == T - 1) && !m_own;
    dv = (p == T - 1) && m_own;
    b  = (p >= 1) && (p <= T - 1);
    c  = (p >= 1) && (p <= N + 1);
    s  = (p == 1);
    return {gu, gv, du, dv, b, c, s, m_shift, m_count, m_sign, m_rot, m_idx};
  endfunction

  task automatic step();
    @(posedge clk);
    cyc++;
    model_update();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_u = 1'b0; req_v = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [18:0] e;
    rst = 1'b1; req_u = 1'b1; req_v = 1'b0; dir_u = 16'h1234; idx_u = 2'd1; rot_u = 1'b1;
    for (int t = 0; t < 3; t++) begin
      step();
      checks++;
      if (dut_vec !== 19'd0) begin
        errors++;
        $display("FAIL reset_outputs t=%0d got=%h exp=0", t, dut_vec);
      end
    end
    rst = 1'b0;
    step();
    e = model_vec();
    checks++;
    if (gnt_u !== 1'b1 || dut_vec !== e) begin
      errors++;
      $display("FAIL reset_first_grant got=%h exp=%h", dut_vec, e);
    end
    req_u = 1'b0;
  endtask

  task automatic test_single_u();
    logic [15:0] d;
    logic [18:0] e;
    do_reset();
    d = 16'hA5A5;
    req_u = 1'b1; dir_u = d; idx_u = 2'd2; rot_u = 1'b1;
    for (int t = 0; t < 22; t++) begin
      step();
      if (t == 0) req_u = 1'b0;
      e = model_vec();
      checks++;
      if (dut_vec !== e) begin
        errors++;
        $display("FAIL single_u_model t=%0d got=%h exp=%h", t, dut_vec, e);
      end
      checks++;
      if (gnt_u !== (t == 0) || sel !== (t == 1) || done_u !== (t == 19) ||
          index !== 2'd2 || sign_rotation !== 1'b1 ||
          (t >= 2 && t <= 17 && (shift !== 4'(t - 2) || count !== 4'(17 - t) ||
                                 sign_in !== d[t - 2]))) begin
        errors++;
        $display("FAIL single_u_direct t=%0d got=%h", t, dut_vec);
      end
    end
  endtask

  task automatic test_alternate();
    logic [18:0] e;
    do_reset();
    req_u = 1'b1; req_v = 1'b1;
    dir_u = 16'h0F0F; dir_v = 16'hF00F; idx_u = 2'd1; idx_v = 2'd3; rot_u = 1'b0; rot_v = 1'b1;
    for (int t = 0; t < 82; t++) begin
      step();
      e = model_vec();
      checks++;
      if (dut_vec !== e) begin
        errors++;
        $display("FAIL alternate_model t=%0d got=%h exp=%h", t, dut_vec, e);
      end
      checks++;
      if (gnt_u !== (t % 40 == 0) || gnt_v !== (t % 40 == 20)) begin
        errors++;
        $display("FAIL alternate_grant t=%0d got_u=%b got_v=%b", t, gnt_u, gnt_v);
      end
    end
    req_u = 1'b0; req_v = 1'b0;
  endtask

  task automatic test_mid_iter();
    logic [18:0] e;
    do_reset();
    req_v = 1'b1; dir_v = 16'h3C96; idx_v = 2'd1; rot_v = 1'b0;
    dir_u = 16'h5555; idx_u = 2'd3; rot_u = 1'b1;
    for (int t = 0; t < 24; t++) begin
      step();
      if (t == 0) req_v = 1'b0;
      if (t == 8) req_u = 1'b1;
      if (t == 20) req_u = 1'b0;
      e = model_vec();
      checks++;
      if (dut_vec !== e) begin
        errors++;
        $display("FAIL mid_iter_model t=%0d got=%h exp=%h", t, dut_vec, e);
      end
      checks++;
      if (gnt_u !== (t == 20) || done_v !== (t == 19)) begin
        errors++;
        $display("FAIL mid_iter_grant t=%0d gnt_u=%b done_v=%b", t, gnt_u, done_v);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [18:0] e;
    do_reset();
    req_u = 1'b1; dir_u = 16'($urandom); idx_u = 2'd3; rot_u = 1'b1;
    for (int t = 0; t < 10; t++) begin
      step();
      if (t == 0) req_u = 1'b0;
      e = model_vec();
      checks++;
      if (dut_vec !== e) begin
        errors++;
        $display("FAIL reset_mid_model t=%0d got=%h exp=%h", t, dut_vec, e);
      end
    end
    checks++;
    if (shift !== 4'd7) begin
      errors++;
      $display("FAIL reset_mid_k got=%0d exp=7", shift);
    end
    rst = 1'b1;
    step();
    checks++;
    if (dut_vec !== 19'd0) begin
      errors++;
      $display("FAIL reset_mid_clear got=%h exp=0", dut_vec);
    end
    rst = 1'b0; req_v = 1'b1; dir_v = 16'hC3A1; idx_v = 2'd2; rot_v = 1'b0;
    for (int t = 0; t < 21; t++) begin
      step();
      if (t == 0) req_v = 1'b0;
      e = model_vec();
      checks++;
      if (dut_vec !== e || gnt_v !== (t == 0) || done_v !== (t == 19) || done_u !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_resume t=%0d got=%h exp=%h", t, dut_vec, e);
      end
    end
  endtask

  task automatic test_pipe3();
    logic [18:0] e;
    do_reset();
    req_u = 1'b1; req_v = 1'b0; dir_u = 16'h9E37; idx_u = 2'd1; rot_u = 1'b0;
    for (int t = 0; t < 46; t++) begin
      step();
      e = model_vec();
      checks++;
      if (dut_vec !== e) begin
        errors++;
        $display("FAIL pipe3_base_model t=%0d got=%h exp=%h", t, dut_vec, e);
      end
      checks++;
      if (gnt3_u !== (t % 22 == 0) || done3_u !== (t % 22 == 21) ||
          ce3 !== ((t % 22) >= 1 && (t % 22) <= 17) ||
          busy3 !== (t % 22 != 0) ||
          ((t % 22) >= 18 && (shift3 !== 4'd15 || count3 !== 4'd0))) begin
        errors++;
        $display("FAIL pipe3_timing t=%0d gnt=%b done=%b ce=%b busy=%b shift=%0d",
                 t, gnt3_u, done3_u, ce3, busy3, shift3);
      end
    end
    req_u = 1'b0;
  endtask

  task automatic test_random();
    logic [18:0] e;
    do_reset();
    for (int t = 0; t < 1500; t++) begin
      req_u = req_u ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 3) == 0);
      req_v = req_v ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 3) == 0);
      dir_u = 16'($urandom); dir_v = 16'($urandom);
      idx_u = 2'($urandom); idx_v = 2'($urandom);
      rot_u = 1'($urandom); rot_v = 1'($urandom);
      rst = ($urandom_range(0, 299) == 0);
      step();
      e = model_vec();
      checks++;
      if (dut_vec !== e) begin
        errors++;
        $display("FAIL random_model t=%0d got=%h exp=%h", t, dut_vec, e);
      end
    end
    rst = 1'b0; req_u = 1'b0; req_v = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_u();
    test_alternate();
    test_mid_iter();
    test_reset_mid();
    test_pipe3();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
